// File: rtl/mem_block_mover.sv
// mem_block_mover: copies N wide blocks (blocks cells each) from a source
// base to a destination base in a single-port cell memory, reporting
// busy/done/error through a status word with its own write strobe.
// Optional checksum of the copied cells: define MEM_BLOCK_MOVER_CHECKSUM_EN.
module mem_block_mover #(
    parameter int size       = 1024,
    parameter int blocks     = 4,
    parameter int log_size   = 10,
    parameter int cell_width = 32,
    parameter int width      = blocks * cell_width
) (
    input  logic                  in_clk,
    input  logic                  in_reset,
    input  logic [cell_width-1:0] in_config,
    input  logic [width-1:0]      in_data,
    output logic [log_size-1:0]   out_address,
    output logic [width-1:0]      out_data,
    output logic                  out_read_en,
    output logic                  out_write_en,
    output logic [cell_width-1:0] out_status,
    output logic                  out_write_status_en
);
    // Range checks are done wide enough that base + span can never wrap.
    localparam int EW = log_size + 3;

    typedef enum logic [2:0] {IDLE, CHECK, BUSY, READ, CAPTURE, WRITE, FINISH} state_t;

    state_t                state, state_nx;
    logic                  start_q;   // previous start bit, for edge detection
    logic                  armed;     // start must be seen low after reset before it can fire
    logic                  start_edge;
    logic [log_size-1:0]   src_q, dst_q, cnt_q, k_q;
    logic [width-1:0]      buf_q;
    logic [cell_width-1:0] status_q, status_nx;
    logic [EW-1:0]         span;
    logic                  cfg_err;
    logic [15:0]           csum;
    logic                  unused_cfg;

    assign unused_cfg = in_config[cell_width-2];
    assign start_edge = in_config[cell_width-1] & ~start_q & armed;

`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
    logic [cell_width-1:0] cs_q, cap_xor;

    // XOR of all cells of the word arriving from memory.
    always_comb begin
        cap_xor = '0;
        for (int b = 0; b < blocks; b++)
            cap_xor = cap_xor ^ in_data[b*cell_width +: cell_width];
    end

    // Running XOR of every copied cell; cleared when a new transfer is checked.
    always_ff @(posedge in_clk) begin
        if (in_reset)            cs_q <= '0;
        else if (state == CHECK) cs_q <= '0;
        else if (state == CAPTURE) cs_q <= cs_q ^ cap_xor;
    end

    assign csum = cs_q[31:16] ^ cs_q[15:0];
`else
    assign csum = 16'h0000;
`endif

    // Span of the transfer in cells and the out-of-range / reserved-cell check.
    always_comb begin
        span    = EW'(cnt_q) * EW'(blocks);
        cfg_err = (EW'(src_q) + span > EW'(size)) ||
                  (EW'(dst_q) + span > EW'(size)) ||
                  (dst_q < log_size'(2));
    end

    // State, latched configuration, block counter, write buffer and status register.
    always_ff @(posedge in_clk) begin
        if (in_reset) begin
            state    <= IDLE;
            start_q  <= 1'b0;
            armed    <= 1'b0;
            src_q    <= '0;
            dst_q    <= '0;
            cnt_q    <= '0;
            k_q      <= '0;
            buf_q    <= '0;
            status_q <= '0;
        end else begin
            state   <= state_nx;
            start_q <= in_config[cell_width-1];
            if (!in_config[cell_width-1]) armed <= 1'b1;
            if (state == IDLE && start_edge) begin
                src_q <= in_config[log_size-1:0];
                dst_q <= in_config[2*log_size-1:log_size];
                cnt_q <= in_config[3*log_size-1:2*log_size];
            end
            if (state == CHECK)   k_q   <= '0;
            if (state == CAPTURE) buf_q <= in_data;
            if (state == WRITE)   k_q   <= k_q + log_size'(1);
            if (out_write_status_en) status_q <= status_nx;
        end
    end

    // Next state and memory/status strobes; all strobes are forced off while in reset.
    always_comb begin
        state_nx            = state;
        out_address         = '0;
        out_data            = '0;
        out_read_en         = 1'b0;
        out_write_en        = 1'b0;
        out_write_status_en = 1'b0;
        status_nx           = status_q;
        case (state)
            IDLE: if (start_edge) state_nx = CHECK;
            CHECK: begin
                if (cfg_err) begin
                    out_write_status_en = 1'b1;
                    status_nx           = '0;
                    status_nx[2]        = 1'b1;
                    status_nx[1]        = 1'b1;
                    state_nx            = IDLE;
                end else if (cnt_q == '0) begin
                    state_nx = FINISH;
                end else begin
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                out_write_status_en = 1'b1;
                status_nx           = '0;
                status_nx[0]        = 1'b1;
                state_nx            = READ;
            end
            READ: begin
                out_read_en = 1'b1;
                out_address = src_q + log_size'(blocks) * k_q;
                state_nx    = CAPTURE;
            end
            CAPTURE: state_nx = WRITE;
            WRITE: begin
                out_write_en = 1'b1;
                out_address  = dst_q + log_size'(blocks) * k_q;
                out_data     = buf_q;
                state_nx     = ((k_q + log_size'(1)) == cnt_q) ? FINISH : READ;
            end
            FINISH: begin
                out_write_status_en = 1'b1;
                status_nx           = '0;
                status_nx[1]        = 1'b1;
                status_nx[31:16]    = csum;
                state_nx            = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        if (in_reset) begin
            out_read_en         = 1'b0;
            out_write_en        = 1'b0;
            out_write_status_en = 1'b0;
            out_address         = '0;
            out_data            = '0;
        end
        out_status = out_write_status_en ? status_nx : status_q;
    end
endmodule

// File: tb/tb_mem_block_mover.sv
// Bench for mem_block_mover: behavioural memory, queue-based scoreboard
// fed by a block-copy reference model, randomized and directed transfers.
module tb_mem_block_mover;
    localparam int SIZE = 1024, BLK = 4, LS = 10, CW = 32, W = BLK * CW;

    logic          clk = 1'b0;
    logic          rst;
    logic [CW-1:0] cfg;
    logic [W-1:0]  rdata;
    logic [LS-1:0] addr;
    logic [W-1:0]  wdata;
    logic          rd_en, wr_en, st_en;
    logic [CW-1:0] status;

    always #5 clk = ~clk;

    mem_block_mover dut (
        .in_clk(clk), .in_reset(rst), .in_config(cfg), .in_data(rdata),
        .out_address(addr), .out_data(wdata), .out_read_en(rd_en),
        .out_write_en(wr_en), .out_status(status), .out_write_status_en(st_en)
    );

    int tests = 0, fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Behavioural memory: registered wide read, wide write, plus a backdoor for preloading.
    logic [CW-1:0] mem [SIZE];
    logic [CW-1:0] ref_mem [SIZE];
    logic          bd_en = 1'b0;
    int            bd_addr = 0;
    logic [CW-1:0] bd_val = '0;
    always @(posedge clk) begin
        if (bd_en) mem[bd_addr] <= bd_val;
        for (int b = 0; b < BLK; b++) begin
            if (rd_en && int'(addr) + b < SIZE) rdata[b*CW +: CW] <= mem[int'(addr) + b];
            if (wr_en && int'(addr) + b < SIZE) mem[int'(addr) + b] <= wdata[b*CW +: CW];
        end
    end

    typedef struct { int cyc; logic [CW-1:0] word; } st_e;
    typedef struct { int cyc; logic [LS-1:0] a; logic [W-1:0] d; } wr_e;
    st_e st_q[$];
    wr_e wr_q[$];
    logic [CW-1:0] last_status = '0;

    // Monitor: pops the scoreboard whenever the DUT strobes a status or memory write.
    always @(negedge clk) begin
        st_e se;
        wr_e we;
        if (rd_en || wr_en || st_en)
            check("exclusive_enables", 128'(int'(rd_en) + int'(wr_en) + int'(st_en)), 128'(1));
        if (st_en) begin
            last_status = status;
            if (st_q.size() == 0) check("unexpected_status", 128'(status), 128'(0) - 1);
            else begin
                se = st_q.pop_front();
                check("status_word", 128'(status), 128'(se.word));
                check("status_cycle", 128'(cyc), 128'(se.cyc));
            end
        end
        if (wr_en) begin
            if (wr_q.size() == 0) check("unexpected_write", 128'(addr), 128'(0) - 1);
            else begin
                we = wr_q.pop_front();
                check("write_addr", 128'(addr), 128'(we.a));
                check("write_data", wdata, we.d);
                check("write_cycle", 128'(cyc), 128'(we.cyc));
            end
        end
    end

    task automatic poke(input int a, input logic [CW-1:0] v);
        @(negedge clk);
        bd_en = 1'b1; bd_addr = a; bd_val = v; ref_mem[a] = v;
        @(negedge clk);
        bd_en = 1'b0;
    endtask

    // Reference model: pushes expected strobes/writes for a transfer; copies
    // at most max_blk blocks into ref_mem (fewer when a reset aborts it).
    task automatic expect_xfer(input int s, input int d, input int n, input int t0, input int max_blk);
        logic [CW-1:0] cs;
        logic [W-1:0]  blk;
        cs = '0;
        if (s + 4*n > SIZE || d + 4*n > SIZE || d < 2) begin
            st_q.push_back('{t0 + 1, 32'h0000_0006});
        end else if (n == 0) begin
            st_q.push_back('{t0 + 2, 32'h0000_0002});
        end else begin
            st_q.push_back('{t0 + 2, 32'h0000_0001});
            for (int k = 0; k < n && k < max_blk; k++) begin
                for (int b = 0; b < BLK; b++) begin
                    blk[b*CW +: CW] = ref_mem[s + 4*k + b];
                    cs = cs ^ ref_mem[s + 4*k + b];
                end
                for (int b = 0; b < BLK; b++) ref_mem[d + 4*k + b] = blk[b*CW +: CW];
                wr_q.push_back('{t0 + 5 + 3*k, LS'(d + 4*k), blk});
            end
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
            if (max_blk >= n) st_q.push_back('{t0 + 3 + 3*n, {cs[31:16] ^ cs[15:0], 16'h0002}});
`else
            if (max_blk >= n) st_q.push_back('{t0 + 3 + 3*n, 32'h0000_0002});
`endif
        end
    endtask

    task automatic drain_and_compare(input int lim);
        int bad;
        for (int i = 0; i < lim && (st_q.size() != 0 || wr_q.size() != 0); i++) @(negedge clk);
        check("scoreboard_drained", 128'(st_q.size() + wr_q.size()), 128'(0));
        st_q.delete(); wr_q.delete();
        repeat (3) @(negedge clk);
        cfg[31] = 1'b0;
        @(negedge clk);
        bad = 0;
        for (int i = 0; i < SIZE; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("memory_image", 128'(bad), 128'(0));
    endtask

    task automatic run_xfer(input int s, input int d, input int n);
        int t0;
        @(negedge clk);
        t0 = cyc;
        expect_xfer(s, d, n, t0, n);
        cfg = {1'b1, 1'b0, 10'(n), 10'(d), 10'(s)};
        drain_and_compare(3*n + 20);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, d, n, t0;
        rst = 1'b1;
        cfg = '0;
        for (int i = 0; i < SIZE; i++) begin
            @(negedge clk);
            bd_en = 1'b1; bd_addr = i; bd_val = $urandom; ref_mem[i] = bd_val;
        end
        @(negedge clk);
        bd_en = 1'b0;
        check("reset_read_en", 128'(rd_en), 128'(0));
        check("reset_write_en", 128'(wr_en), 128'(0));
        check("reset_status_en", 128'(st_en), 128'(0));
        check("reset_address", 128'(addr), 128'(0));
        check("reset_data", wdata, 128'(0));
        check("reset_status", 128'(status), 128'(0));
        rst = 1'b0;
        repeat (2) @(negedge clk);

        run_xfer(8, 100, 2);      // basic two-block copy
        run_xfer(1000, 200, 10);  // source out of range
        run_xfer(4, 1, 1);        // destination in reserved cells
        run_xfer(4, 2, 1);        // lowest legal destination
        run_xfer(16, 300, 0);     // empty transfer
        run_xfer(256, 260, 3);    // overlapping forward copy
        run_xfer(0, 1020, 1);     // destination ends exactly at top
        run_xfer(0, 1020, 2);     // destination one block past top

        poke(40, 32'h0000_FFFF);
        poke(41, 32'h1234_0000);
        poke(42, 32'h0);
        poke(43, 32'h0);
        run_xfer(40, 500, 1);
`ifdef MEM_BLOCK_MOVER_CHECKSUM_EN
        check("checksum_field", 128'(last_status[31:16]), 128'(16'hEDCB));
`else
        check("checksum_field", 128'(last_status[31:16]), 128'(16'h0000));
`endif

        for (int it = 0; it < 14; it++) begin
            n = $urandom_range(0, 5);
            s = $urandom_range(0, SIZE - 4*n);
            d = $urandom_range(2, SIZE - 4*n);
            case ($urandom_range(0, 4))
                0: d = (s + 4 + 4*n <= SIZE && s + 4 >= 2) ? s + 4 : d;
                1: begin n = n + 1; s = SIZE - 4*n + $urandom_range(1, 3); end
                2: d = $urandom_range(0, 1);
                default: ;
            endcase
            run_xfer(s, d, n);
        end

        // Reset during the second READ of a three-block transfer.
        @(negedge clk);
        t0 = cyc;
        expect_xfer(600, 700, 3, t0, 1);
        cfg = {1'b1, 1'b0, 10'd3, 10'd700, 10'd600};
        for (int i = 0; i < 40 && cyc < t0 + 6; i++) @(negedge clk);
        check("second_read_seen", 128'(rd_en), 128'(1));
        rst = 1'b1;
        @(negedge clk);
        check("abort_read_en", 128'(rd_en), 128'(0));
        check("abort_write_en", 128'(wr_en), 128'(0));
        check("abort_status_en", 128'(st_en), 128'(0));
        check("abort_address", 128'(addr), 128'(0));
        check("abort_status", 128'(status), 128'(0));
        rst = 1'b0;
        repeat (20) @(negedge clk);   // start still high: nothing may happen
        drain_and_compare(2);

        run_xfer(64, 900, 2);         // recovers after start is re-raised

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
